checksum_checker: RTL and testbench
===================================

// Module: checksum_checker
// PURPOSE
//  Receive-side partner of checksum_core. Accepts a frame of p_WORD_LEN-bit words whose last word is the
//  sender's checksum, and sums every word including the checksum. At frame end it reports pass/fail.
//  Sits after the link receiver, before frame consumers.
// PARAMETERS
//  p_WORD_LEN   8    word/checksum width in bits (>=2)
//  p_TWOS_COMPL 0    0: ones'-complement sum (end-around carry); 1: two's-complement sum (mod 2^W)
//  p_MAX_WORDS  256  max words per frame incl. checksum; used only with CHECKSUM_CHK_LEN_LIMIT_EN
// PORTS
//  i_clk       in   1  clock, rising edge
//  i_reset     in   1  reset, asynchronous, active-high
//  i_data      in   W  frame word
//  i_valid     in   1  i_data valid
//  i_last      in   1  with i_valid: this word is the checksum (frame end)
//  i_clear     in   1  synchronous abort of the current frame
//  o_ready     out  1  block accepts a word this cycle
//  o_done      out  1  one-cycle pulse: result valid
//  o_pass      out  1  last frame checked OK (held)
//  o_fail      out  1  last frame checksum mismatch or length error (held)
//  o_len_err   out  1  last frame exceeded p_MAX_WORDS (held; tied 0 when macro off)
//  o_sum       out  W  running accumulator (debug)
// BEHAVIOUR
//  Reset, asynchronous, active-high: state=IDLE, acc=0, count=0. o_ready=1; o_done, o_pass, o_fail and o_len_err =0; o_sum=0.
//  Accept = i_valid & o_ready. Non-accepted cycles leave all state unchanged.
//  FSM IDLE -> ACCUM on first accept without i_last.
//  IDLE/ACCUM -> RESULT on accept with i_last (a 1-word frame is legal).
//  RESULT -> IDLE after exactly 1 cycle.
//  First accept of a frame loads acc from 0: acc_next = add(0, i_data).
//  It also clears o_pass, o_fail and o_len_err.
//  Ones'-compl add: s = {1'b0,acc}+{1'b0,d}; acc_next = s[W-1:0] + s[W]. Pass iff final acc == all-ones.
//  Two's-compl add: acc_next = (acc + d) mod 2^W. Pass iff final acc == 0.
//  Latency: o_done asserts in the cycle after the i_last word is accepted (registered compare).
//  o_pass or o_fail is valid in that same cycle and held until the next frame's first accept, i_clear, or reset.
//  o_ready=0 only in RESULT; every other state accepts one word per cycle.
//  o_pass and o_fail are mutually exclusive. Both are 0 while a frame is in progress.
//  i_clear in any state: go to IDLE, acc=0, count=0, clear o_pass/o_fail/o_len_err, no o_done.
//  i_clear beats a simultaneous accept; that word is dropped.
//  Reset mid-frame discards the frame with no o_done.
//  Word counter: saturating, width $clog2(p_MAX_WORDS+1). It counts accepted words in the frame.
// CONFIGURATION
//  `CHECKSUM_CHK_LEN_LIMIT_EN defined: accepting word number p_MAX_WORDS+1 without i_last sets a sticky length-error flag.
//   Summing continues. At frame end o_fail=1, o_len_err=1, o_pass=0, whatever the sum.
//  Not defined: no length limit, counter logic removed, o_len_err tied 0.
// STRUCTURE
//  checksum_pkg: FSM state localparams (IDLE/ACCUM/RESULT) and function csum_add(acc,d,twos)
//   for the add rule above. checksum_core shares the function.
//  Sub-module csum_adder (combinational W-bit adder with end-around-carry option), instantiated once.
//  Top holds the FSM, accumulator, counter and result registers.
// TESTING (W=8 unless noted)
//  1 Ones': 0x12,0x34, then 0xB9 with last -> o_done 1 cycle later, o_pass=1, o_sum=0xFF.
//  2 End-around carry: 0xFF,0x01, then 0xFE with last -> acc 0x01 after the 2nd word; o_pass=1.
//  3 Corrupt: 0x12,0x35, then 0xB9 with last -> o_fail=1, o_pass=0. 1-word frame 0xFF with last -> pass.
//  4 p_TWOS_COMPL=1: 0x12,0x34, then 0xBA with last -> acc 0x00, o_pass=1. Then 0xBB -> o_fail.
//  5 Reset mid-frame after 0x12, then i_clear together with a valid word -> no o_done, outputs 0,
//   the next frame computes from acc=0, o_ready=0 only in the RESULT cycle.
//  6 Macro on, p_MAX_WORDS=4: 5 data words, then a correct checksum -> o_len_err=1, o_fail=1.
//   A 4-word frame passes.

Source files
------------

// File: rtl/checksum_pkg.sv
// rtl/checksum_pkg.sv - shared FSM states and checksum add rule
// Purpose: FSM state encoding for checksum_checker and the csum_add
//   function, which is also shared with checksum_core.
// Ports: none (package).
package checksum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Widest word the shared add rule supports; callers zero-extend into it.
  localparam int CSUM_MAX_W = 64;

  // Adds two w-bit values held in the low bits of acc and d.
  // twos=0: ones'-complement add with end-around carry.
  // twos=1: plain modulo-2^w add.
  function automatic logic [CSUM_MAX_W-1:0] csum_add(
    input logic [CSUM_MAX_W-1:0] acc,
    input logic [CSUM_MAX_W-1:0] d,
    input int unsigned           w,
    input logic                  twos
  );
    logic [CSUM_MAX_W:0] s;
    logic [CSUM_MAX_W:0] mask;
    logic [CSUM_MAX_W:0] r;
    mask = ({{CSUM_MAX_W{1'b0}}, 1'b1} << w) - {{CSUM_MAX_W{1'b0}}, 1'b1};
    s    = {1'b0, acc} + {1'b0, d};
    r    = s & mask;
    // Folding the carry back in cannot overflow again: r <= 2^w-2 when carry=1.
    if (!twos) begin
      r = (r + {{CSUM_MAX_W{1'b0}}, s[w]}) & mask;
    end
    return r[CSUM_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/checksum_checker_if.sv
// rtl/checksum_checker_if.sv - frame input / result output bundle
// Purpose: groups the word stream, abort and result signals of checksum_checker.
// Ports (signals):
//   i_data, i_valid, i_last, i_clear : master -> checker
//   o_ready, o_done, o_pass, o_fail, o_len_err, o_sum : checker -> master
interface checksum_checker_if #(
  parameter int p_WORD_LEN = 8
);
  logic [p_WORD_LEN-1:0] i_data;
  logic                  i_valid;
  logic                  i_last;
  logic                  i_clear;
  logic                  o_ready;
  logic                  o_done;
  logic                  o_pass;
  logic                  o_fail;
  logic                  o_len_err;
  logic [p_WORD_LEN-1:0] o_sum;

  modport master (
    output i_data, i_valid, i_last, i_clear,
    input  o_ready, o_done, o_pass, o_fail, o_len_err, o_sum
  );

  modport slave (
    input  i_data, i_valid, i_last, i_clear,
    output o_ready, o_done, o_pass, o_fail, o_len_err, o_sum
  );
endinterface

// File: rtl/csum_adder.sv
// rtl/csum_adder.sv - combinational W-bit checksum adder
// Purpose: one add step of the checksum, ones'- or two's-complement.
// Ports:
//   a_i   in  W  accumulator operand
//   b_i   in  W  data operand
//   sum_o out W  a_i + b_i under the selected rule
module csum_adder
  import checksum_pkg::*;
#(
  parameter int p_WORD_LEN   = 8,
  parameter int p_TWOS_COMPL = 0
) (
  input  logic [p_WORD_LEN-1:0] a_i,
  input  logic [p_WORD_LEN-1:0] b_i,
  output logic [p_WORD_LEN-1:0] sum_o
);

  assign sum_o = p_WORD_LEN'(csum_add(CSUM_MAX_W'(a_i), CSUM_MAX_W'(b_i),
                                      p_WORD_LEN, (p_TWOS_COMPL != 0)));

endmodule

// File: rtl/checksum_checker.sv
// rtl/checksum_checker.sv - receive-side frame checksum checker
// Purpose: sums every word of a frame including the trailing checksum and
//   reports pass/fail one cycle after the last word is accepted.
// Optional feature: `CHECKSUM_CHK_LEN_LIMIT_EN enables the p_MAX_WORDS
//   frame length limit (o_len_err); without it o_len_err is tied 0.
// Ports:
//   i_clk   in  clock, rising edge
//   i_reset in  asynchronous active-high reset
//   bus     slave modport of checksum_checker_if:
//     i_data/i_valid/i_last word stream, i_clear abort,
//     o_ready, o_done pulse, o_pass/o_fail/o_len_err held result, o_sum accumulator
module checksum_checker
  import checksum_pkg::*;
#(
  parameter int p_WORD_LEN   = 8,
  parameter int p_TWOS_COMPL = 0,
  parameter int p_MAX_WORDS  = 256
) (
  input  logic                i_clk,
  input  logic                i_reset,
  checksum_checker_if.slave   bus
);

  if (p_WORD_LEN < 2 || p_WORD_LEN > CSUM_MAX_W || p_MAX_WORDS < 1) begin : g_bad_param
    $error("checksum_checker: unsupported parameter values");
  end

  // Final accumulator value of a good frame.
  localparam logic [p_WORD_LEN-1:0] PASS_VAL =
    (p_TWOS_COMPL != 0) ? {p_WORD_LEN{1'b0}} : {p_WORD_LEN{1'b1}};

  state_t                state_q, state_d;
  logic [p_WORD_LEN-1:0] acc_q, acc_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  ready;
  logic                  accept;
  logic                  first;
  logic [p_WORD_LEN-1:0] add_a;
  logic [p_WORD_LEN-1:0] add_sum;
  logic                  frame_err;

  assign ready  = (state_q != ST_RESULT);
  assign accept = bus.i_valid & ready;
  assign first  = (state_q == ST_IDLE);
  // A frame's first word adds onto zero, so the previous result needs no clear cycle.
  assign add_a  = first ? {p_WORD_LEN{1'b0}} : acc_q;

  csum_adder #(
    .p_WORD_LEN   (p_WORD_LEN),
    .p_TWOS_COMPL (p_TWOS_COMPL)
  ) u_adder (
    .a_i   (add_a),
    .b_i   (bus.i_data),
    .sum_o (add_sum)
  );

`ifdef CHECKSUM_CHK_LEN_LIMIT_EN
  localparam int CNT_W = $clog2(p_MAX_WORDS + 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             lflag_q, lflag_d;   // length exceeded within the current frame
  logic             lerr_q, lerr_d;     // held result flag
  logic             len_hit;

  // Word p_MAX_WORDS+1 arriving as data (not the checksum) overruns the frame.
  assign len_hit   = accept & ~first & ~bus.i_last & (count_q == CNT_W'(p_MAX_WORDS));
  assign frame_err = lflag_q | len_hit;
`else
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef CHECKSUM_CHK_LEN_LIMIT_EN
    count_d = count_q;
    lflag_d = lflag_q;
    lerr_d  = lerr_q;
`endif
    if (bus.i_clear) begin
      // Abort wins over a simultaneous accept; the word is dropped.
      state_d = ST_IDLE;
      acc_d   = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
`ifdef CHECKSUM_CHK_LEN_LIMIT_EN
      count_d = '0;
      lflag_d = 1'b0;
      lerr_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            if (first) begin
              pass_d = 1'b0;
              fail_d = 1'b0;
            end
`ifdef CHECKSUM_CHK_LEN_LIMIT_EN
            if (first) begin
              count_d = CNT_W'(1);
              lflag_d = 1'b0;
              lerr_d  = 1'b0;
            end else begin
              if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
              lflag_d = frame_err;
            end
`endif
            if (bus.i_last) begin
              state_d = ST_RESULT;
              pass_d  = ~frame_err & (add_sum == PASS_VAL);
              fail_d  = frame_err | (add_sum != PASS_VAL);
`ifdef CHECKSUM_CHK_LEN_LIMIT_EN
              lerr_d  = frame_err;
`endif
            end else begin
              state_d = ST_ACCUM;
            end
          end
        end
        ST_RESULT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

`ifdef CHECKSUM_CHK_LEN_LIMIT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
      lflag_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      lflag_q <= lflag_d;
      lerr_q  <= lerr_d;
    end
  end
  assign bus.o_len_err = lerr_q;
`else
  assign bus.o_len_err = 1'b0;
`endif

  assign bus.o_ready = ready;
  // An abort during the result cycle suppresses the pulse.
  assign bus.o_done  = (state_q == ST_RESULT) & ~bus.i_clear;
  assign bus.o_pass  = pass_q;
  assign bus.o_fail  = fail_q;
  assign bus.o_sum   = acc_q;

endmodule

// File: tb/tb_checksum_checker.sv
// tb/tb_checksum_checker.sv - scoreboard bench for checksum_checker
module tb_checksum_checker;

  typedef struct {
    logic [7:0] sum;
    logic       pass;
    logic       fail;
    logic       len;
  } exp_t;

`ifdef CHECKSUM_CHK_LEN_LIMIT_EN
  localparam logic LEN_ON = 1'b1;
`else
  localparam logic LEN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  checksum_checker_if #(.p_WORD_LEN(8)) ifa ();
  checksum_checker_if #(.p_WORD_LEN(8)) ifb ();

  checksum_checker #(.p_WORD_LEN(8), .p_TWOS_COMPL(0), .p_MAX_WORDS(4)) dut_a (
    .i_clk (clk), .i_reset (rst), .bus (ifa)
  );
  checksum_checker #(.p_WORD_LEN(8), .p_TWOS_COMPL(1), .p_MAX_WORDS(4)) dut_b (
    .i_clk (clk), .i_reset (rst), .bus (ifb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every o_done pops one expected result; o_ready must be low exactly in the result cycle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      chk("a_ready_vs_done", {31'd0, ifa.o_ready}, {31'd0, ~ifa.o_done});
      if (ifa.o_done === 1'b1) begin
        if (qa.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
        else begin
          e = qa.pop_front();
          chk("a_result", {21'd0, ifa.o_sum, ifa.o_pass, ifa.o_fail, ifa.o_len_err},
                          {21'd0, e.sum, e.pass, e.fail, e.len});
        end
      end
      chk("b_ready_vs_done", {31'd0, ifb.o_ready}, {31'd0, ~ifb.o_done});
      if (ifb.o_done === 1'b1) begin
        if (qb.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
        else begin
          e = qb.pop_front();
          chk("b_result", {21'd0, ifb.o_sum, ifb.o_pass, ifb.o_fail, ifb.o_len_err},
                          {21'd0, e.sum, e.pass, e.fail, e.len});
        end
      end
    end
  end

  function automatic logic rdy(input int s);
    return (s == 0) ? ifa.o_ready : ifb.o_ready;
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] d, input logic l, input logic c);
    if (s == 0) begin
      ifa.i_valid = v; ifa.i_data = d; ifa.i_last = l; ifa.i_clear = c;
    end else begin
      ifb.i_valid = v; ifb.i_data = d; ifb.i_last = l; ifb.i_clear = c;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input int s, input logic [7:0] d, input logic l);
    int w = 0;
    while (rdy(s) !== 1'b1 && w < 8) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 8) chk("ready_timeout", 32'd1, 32'd0);
    drive(s, 1'b1, d, l, 1'b0);
    @(posedge clk); #1;
    drive(s, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ifa.o_ready}, 32'd1);
    chk("rst_outs", {28'd0, ifa.o_done, ifa.o_pass, ifa.o_fail, ifa.o_len_err}, 32'd0);
    chk("rst_sum", {24'd0, ifa.o_sum}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: ones' basic
    send(0, 8'h12, 1'b0);
    send(0, 8'h34, 1'b0);
    chk("t1_acc2", {24'd0, ifa.o_sum}, 32'h46);
    qa.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    send(0, 8'hB9, 1'b1);
    chk("t1_done_next_cycle", {31'd0, ifa.o_done}, 32'd1);
    @(posedge clk); #1;
    chk("t1_pass_held", {30'd0, ifa.o_pass, ifa.o_done}, 32'b10);

    // 2: end-around carry
    send(0, 8'hFF, 1'b0);
    chk("t2_result_cleared", {30'd0, ifa.o_pass, ifa.o_fail}, 32'd0);
    send(0, 8'h01, 1'b0);
    chk("t2_eac", {24'd0, ifa.o_sum}, 32'h01);
    qa.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    send(0, 8'hFE, 1'b1);

    // 3: corrupt frame, then 1-word frame, then clear of held result
    send(0, 8'h12, 1'b0);
    send(0, 8'h35, 1'b0);
    qa.push_back('{8'h01, 1'b0, 1'b1, 1'b0});
    send(0, 8'hB9, 1'b1);
    qa.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    send(0, 8'hFF, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_clear_result", {30'd0, ifa.o_pass, ifa.o_fail}, 32'd0);

    // 4: two's complement
    send(1, 8'h12, 1'b0);
    send(1, 8'h34, 1'b0);
    qb.push_back('{8'h00, 1'b1, 1'b0, 1'b0});
    send(1, 8'hBA, 1'b1);
    send(1, 8'h12, 1'b0);
    send(1, 8'h34, 1'b0);
    qb.push_back('{8'h01, 1'b0, 1'b1, 1'b0});
    send(1, 8'hBB, 1'b1);

    // 5: reset mid-frame, clear with a simultaneous word, then a fresh frame
    send(0, 8'h12, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_sum", {24'd0, ifa.o_sum}, 32'd0);
    chk("t5_rst_outs", {27'd0, ifa.o_ready, ifa.o_done, ifa.o_pass, ifa.o_fail, ifa.o_len_err}, 32'b10000);
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 8'h20, 1'b0);
    drive(0, 1'b1, 8'h55, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_clear_acc", {24'd0, ifa.o_sum}, 32'd0);
    send(0, 8'h12, 1'b0);
    send(0, 8'h34, 1'b0);
    qa.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    send(0, 8'hB9, 1'b1);

    // 6: length limit (p_MAX_WORDS=4)
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    send(0, 8'h03, 1'b0);
    send(0, 8'h04, 1'b0);
    send(0, 8'h05, 1'b0);
    qa.push_back('{8'hFF, ~LEN_ON, LEN_ON, LEN_ON});
    send(0, 8'hF0, 1'b1);
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    send(0, 8'h03, 1'b0);
    qa.push_back('{8'hFF, 1'b1, 1'b0, 1'b0});
    send(0, 8'hF9, 1'b1);

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
